// File: rtl/fdma_w_arbiter.sv
// fdma_w_arbiter: shares one FDMA write channel among N_CH frame-buffer
// write clients, granting one complete burst at a time.
// Build option: define FDMA_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise arbitration is round-robin from the last owner.
//
// state  | meaning
// S_IDLE | no owner, waiting for any client request
// S_REQ  | burst latched, master request raised, waiting for master busy
// S_BUSY | master moving the burst, beats routed to the owner
// S_GAP  | one dead cycle so the owner sees wbusy low before re-requesting
module fdma_w_arbiter #(
  parameter int N_CH           = 4,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                           I_ui_clk,
  input  logic                           I_ui_rst,
  input  logic [N_CH*AXI_ADDR_WIDTH-1:0] I_ch_waddr,
  input  logic [N_CH-1:0]                I_ch_wareq,
  input  logic [N_CH*16-1:0]             I_ch_wsize,
  input  logic [N_CH*AXI_DATA_WIDTH-1:0] I_ch_wdata,
  output logic [N_CH-1:0]                O_ch_wbusy,
  output logic [N_CH-1:0]                O_ch_wvalid,
  output logic [AXI_ADDR_WIDTH-1:0]      O_fdma_waddr,
  output logic                           O_fdma_wareq,
  output logic [15:0]                    O_fdma_wsize,
  input  logic                           I_fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0]      O_fdma_wdata,
  input  logic                           I_fdma_wvalid,
  output logic [N_CH-1:0]                O_grant,
  output logic                           O_len_err
);

  localparam int PTR_W = $clog2(N_CH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_GAP} state_t;

  state_t                    state_q, state_d;
  logic [N_CH-1:0]           grant_q, grant_d;
  logic [PTR_W-1:0]          own_q, own_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]               wsize_q, wsize_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      wareq_q, wareq_d;
  logic                      len_err_q, len_err_d;

  logic                      sel_found;
  logic [PTR_W-1:0]          sel_idx;
  logic [AXI_ADDR_WIDTH-1:0] sel_waddr;
  logic [15:0]               sel_wsize;
  logic [AXI_DATA_WIDTH-1:0] wdata_mux;
  logic                      fwd_beat;

`ifdef FDMA_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is kept last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (I_ch_wareq[k]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(k);
      end
    end
  end
`else
  logic [PTR_W:0]   cand_sum;
  logic [PTR_W-1:0] cand;

  // Round-robin: scan from ptr+N down to ptr+1 so ptr+1 has the final say.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(N_CH)) cand_sum = cand_sum - (PTR_W+1)'(N_CH);
      cand = cand_sum[PTR_W-1:0];
      if (I_ch_wareq[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end
`endif

  // Pick the selected client's address and size, and the owner's data.
  always_comb begin
    sel_waddr = '0;
    sel_wsize = '0;
    wdata_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_waddr = I_ch_waddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_wsize = I_ch_wsize[i*16 +: 16];
      end
      if (grant_q[i]) wdata_mux = I_ch_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  // Next-state and next-output logic; grant is only non-zero in S_REQ/S_BUSY.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    waddr_d   = waddr_q;
    wsize_d   = wsize_q;
    wareq_d   = wareq_q;
    len_err_d = len_err_q;
    fwd_beat  = I_fdma_wvalid && (grant_q != '0);
    cnt_d     = (fwd_beat && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    if (I_fdma_wvalid && (grant_q == '0)) len_err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = N_CH'(1) << sel_idx;
          own_d   = sel_idx;
          waddr_d = sel_waddr;
          wsize_d = sel_wsize;
          wareq_d = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (I_fdma_wbusy) begin
          wareq_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!I_fdma_wbusy) begin
          if (cnt_d != wsize_q) len_err_d = 1'b1;
          ptr_d   = own_q;
          grant_d = '0;
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      own_q     <= '0;
      ptr_q     <= PTR_W'(N_CH - 1);
      waddr_q   <= '0;
      wsize_q   <= '0;
      cnt_q     <= '0;
      wareq_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      waddr_q   <= waddr_d;
      wsize_q   <= wsize_d;
      cnt_q     <= cnt_d;
      wareq_q   <= wareq_d;
      len_err_q <= len_err_d;
    end
  end

  assign O_grant      = grant_q;
  assign O_ch_wbusy   = grant_q;
  assign O_ch_wvalid  = {N_CH{I_fdma_wvalid}} & grant_q;
  assign O_fdma_waddr = waddr_q;
  assign O_fdma_wsize = wsize_q;
  assign O_fdma_wareq = wareq_q;
  assign O_fdma_wdata = wdata_mux;
  assign O_len_err    = len_err_q;

endmodule

// File: tb/tb_fdma_w_arbiter.sv
// Directed testbench for fdma_w_arbiter (default 4 clients, 128/32 bit).
module tb_fdma_w_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ch_waddr = '0;
  logic [3:0]   ch_wareq = '0;
  logic [63:0]  ch_wsize = '0;
  logic [511:0] ch_wdata = '0;
  logic [3:0]   ch_wbusy, ch_wvalid, grant;
  logic [31:0]  m_waddr;
  logic         m_wareq;
  logic [15:0]  m_wsize;
  logic         m_wbusy = 1'b0;
  logic [127:0] m_wdata;
  logic         m_wvalid = 1'b0;
  logic         len_err;

  int tests_run = 0;
  int tests_failed = 0;

  fdma_w_arbiter dut (
    .I_ui_clk(clk), .I_ui_rst(rst),
    .I_ch_waddr(ch_waddr), .I_ch_wareq(ch_wareq), .I_ch_wsize(ch_wsize), .I_ch_wdata(ch_wdata),
    .O_ch_wbusy(ch_wbusy), .O_ch_wvalid(ch_wvalid),
    .O_fdma_waddr(m_waddr), .O_fdma_wareq(m_wareq), .O_fdma_wsize(m_wsize),
    .I_fdma_wbusy(m_wbusy), .O_fdma_wdata(m_wdata), .I_fdma_wvalid(m_wvalid),
    .O_grant(grant), .O_len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    ch_wareq = '0;
    m_wbusy  = 1'b0;
    m_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++;
    if (grant !== 4'b0 || ch_wbusy !== 4'b0 || m_wareq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: grant=%b wbusy=%b wareq=%b, want 0/0/0", grant, ch_wbusy, m_wareq);
    end
    tests_run++;
    if (m_waddr !== 32'h0 || m_wsize !== 16'h0 || len_err !== 1'b0 || m_wdata !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_data: waddr=%h wsize=%h len_err=%b wdata=%h, want zeros", m_waddr, m_wsize, len_err, m_wdata);
    end
  endtask

  task automatic test_single_burst;
    int pulses = 0;
    int stray = 0;
    do_reset();
    ch_waddr[2*32 +: 32] = 32'h0000_1000;
    ch_wsize[2*16 +: 16] = 16'd240;
    ch_wareq = 4'b0100;
    tick();
    tests_run++;
    if (grant !== 4'b0100 || m_wareq !== 1'b1 || ch_wbusy !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_grant: grant=%b wareq=%b wbusy=%b, want 0100/1/0100", grant, m_wareq, ch_wbusy);
    end
    tests_run++;
    if (m_waddr !== 32'h1000 || m_wsize !== 16'd240) begin
      tests_failed++;
      $display("FAIL single_latch: waddr=%h wsize=%0d, want 1000/240", m_waddr, m_wsize);
    end
    tests_run++;
    if (m_wdata !== 128'hC2C2_0000_0000_0000_0000_0000_0000_0002) begin
      tests_failed++;
      $display("FAIL single_wdata: wdata=%h, want client 2 slice", m_wdata);
    end
    ch_wareq = 4'b0;
    m_wbusy  = 1'b1;
    tick();
    tests_run++;
    if (m_wareq !== 1'b0 || ch_wbusy !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_busy: wareq=%b wbusy=%b, want 0/0100", m_wareq, ch_wbusy);
    end
    for (int i = 0; i < 245; i++) begin
      m_wvalid = (i < 240);
      #1;
      if (ch_wvalid == 4'b0100) pulses++;
      if ((ch_wvalid & 4'b1011) != 4'b0) stray++;
      tick();
    end
    m_wvalid = 1'b0;
    m_wbusy  = 1'b0;
    tick();
    tests_run++;
    if (pulses !== 240 || stray !== 0) begin
      tests_failed++;
      $display("FAIL single_beats: pulses=%0d stray=%0d, want 240/0", pulses, stray);
    end
    tests_run++;
    if (grant !== 4'b0 || ch_wbusy !== 4'b0 || len_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_gap: grant=%b wbusy=%b len_err=%b, want 0/0/0", grant, ch_wbusy, len_err);
    end
  endtask

  task automatic test_round_robin;
    int gaps;
    logic [3:0] exp_g;
    do_reset();
    ch_wsize = '0;
    ch_wareq = 4'hF;
    for (int b = 0; b < 5; b++) begin
      gaps = 0;
      while (grant == 4'b0 && gaps < 10) begin
        tick();
        gaps++;
      end
`ifdef FDMA_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (b % 4);
`endif
      tests_run++;
      if (grant !== exp_g) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: grant=%b, want %b", b, grant, exp_g);
      end
      tests_run++;
      if (gaps !== ((b == 0) ? 1 : 2)) begin
        tests_failed++;
        $display("FAIL rr_gap%0d: idle cycles=%0d, want %0d", b, gaps, (b == 0) ? 1 : 2);
      end
      m_wbusy = 1'b1;
      tick();
      m_wbusy = 1'b0;
      tick();
    end
    ch_wareq = 4'b0;
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_len_err: len_err=%b, want 0", len_err);
    end
  endtask

  task automatic test_latched_addr;
    int bad = 0;
    do_reset();
    ch_waddr[1*32 +: 32] = 32'h0000_2000;
    ch_wsize[1*16 +: 16] = 16'd4;
    ch_wareq = 4'b0010;
    tick();
    tests_run++;
    if (grant !== 4'b0010 || m_waddr !== 32'h2000 || m_wsize !== 16'd4) begin
      tests_failed++;
      $display("FAIL latch_grant: grant=%b waddr=%h wsize=%0d, want 0010/2000/4", grant, m_waddr, m_wsize);
    end
    m_wbusy = 1'b1;
    tick();
    ch_wareq = 4'b0;
    ch_waddr[1*32 +: 32] = 32'h0000_DEAD;
    for (int i = 0; i < 4; i++) begin
      m_wvalid = 1'b1;
      #1;
      if (m_waddr !== 32'h2000) bad++;
      if (m_wdata !== 128'hC1C1_0000_0000_0000_0000_0000_0000_0001) bad++;
      tick();
    end
    m_wvalid = 1'b0;
    m_wbusy  = 1'b0;
    tests_run++;
    if (bad !== 0 || m_waddr !== 32'h2000) begin
      tests_failed++;
      $display("FAIL latch_hold: bad samples=%0d waddr=%h, want 0/2000", bad, m_waddr);
    end
    tick();
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL latch_len_err: len_err=%b, want 0", len_err);
    end
  endtask

  task automatic test_len_err;
    do_reset();
    ch_wsize[0*16 +: 16] = 16'd16;
    ch_wareq = 4'b0001;
    tick();
    ch_wareq = 4'b0;
    m_wbusy  = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      m_wvalid = 1'b1;
      tick();
    end
    m_wvalid = 1'b0;
    m_wbusy  = 1'b0;
    tick();
    tests_run++;
    if (len_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL len_short: len_err=%b, want 1", len_err);
    end
    ch_wsize[0*16 +: 16] = 16'd0;
    ch_wareq = 4'b0001;
    repeat (2) tick();
    ch_wareq = 4'b0;
    m_wbusy  = 1'b1;
    tick();
    m_wbusy = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (len_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL len_sticky: len_err=%b, want 1", len_err);
    end
    do_reset();
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL len_clear: len_err=%b, want 0", len_err);
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    ch_waddr[3*32 +: 32] = 32'h0000_3000;
    ch_wsize[3*16 +: 16] = 16'd8;
    ch_wareq = 4'b1000;
    tick();
    ch_wareq = 4'b0;
    m_wbusy  = 1'b1;
    tick();
    tests_run++;
    if (grant !== 4'b1000 || ch_wbusy !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mid_setup: grant=%b wbusy=%b, want 1000/1000", grant, ch_wbusy);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0 || ch_wbusy !== 4'b0 || m_wareq !== 1'b0 || m_waddr !== 32'h0 ||
        m_wsize !== 16'h0 || m_wdata !== 128'h0 || len_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_async: grant=%b wbusy=%b waddr=%h wsize=%h, want all zero", grant, ch_wbusy, m_waddr, m_wsize);
    end
    m_wbusy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ch_wareq = 4'b0001;
    tick();
    tests_run++;
    if (grant !== 4'b0001 || m_wareq !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_regrant: grant=%b wareq=%b, want 0001/1", grant, m_wareq);
    end
    ch_wareq = 4'b0;
  endtask

  task automatic test_idle_wvalid;
    do_reset();
    m_wvalid = 1'b1;
    #1;
    tests_run++;
    if (ch_wvalid !== 4'b0) begin
      tests_failed++;
      $display("FAIL idle_fwd: ch_wvalid=%b, want 0000", ch_wvalid);
    end
    tick();
    m_wvalid = 1'b0;
    tests_run++;
    if (len_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_len_err: len_err=%b, want 1", len_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ch_wdata[i*128 +: 128] = {8'hC0 + 8'(i), 8'hC0 + 8'(i), 104'h0, 8'(i)};
      ch_waddr[i*32 +: 32]   = 32'hA000_0000 + 32'(i);
    end
    test_reset();
    test_single_burst();
    test_round_robin();
    test_latched_addr();
    test_len_err();
    test_reset_mid_burst();
    test_idle_wvalid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fdma_w_arbiter.md
Name: fdma_w_arbiter

Overview:
- Shares one FDMA write channel among N frame-buffer write clients. In the four-split-screen design these are four write-only buffer controllers, one per video input.
- Grants one complete FDMA burst at a time, round-robin.
- Routes the master's wvalid/wbusy to the granted client and muxes that client's address, size and data onto the master.
- Sits between the write-only buffer controllers and the single FDMA/AXI master in the I_ui_clk domain.

Parameters:
- N_CH, 4, number of write clients (2..8).
- AXI_DATA_WIDTH, 128, FDMA write data width.
- AXI_ADDR_WIDTH, 32, FDMA address width.

Ports:
- I_ui_clk  in  1  FDMA/AXI user clock; only clock.
- I_ui_rst  in  1  asynchronous, active-high reset.
- I_ch_waddr  in  N_CH*AXI_ADDR_WIDTH  per-client burst address, client i in slice i.
- I_ch_wareq  in  N_CH  per-client burst request; level, held until the client sees its wbusy high.
- I_ch_wsize  in  N_CH*16  per-client burst length in beats.
- I_ch_wdata  in  N_CH*AXI_DATA_WIDTH  per-client show-ahead FIFO data.
- O_ch_wbusy  out  N_CH  per-client busy.
- O_ch_wvalid  out  N_CH  per-client read strobe (beat consumed).
- O_fdma_waddr  out  AXI_ADDR_WIDTH  master address.
- O_fdma_wareq  out  1  master request.
- O_fdma_wsize  out  16  master burst length.
- I_fdma_wbusy  in  1  master busy.
- O_fdma_wdata  out  AXI_DATA_WIDTH  master write data.
- I_fdma_wvalid  in  1  master beat strobe.
- O_grant  out  N_CH  one-hot current owner; zero when idle.
- O_len_err  out  1  sticky: a burst's beat count differed from its wsize.

Behaviour:
- Reset (async, I_ui_rst=1):
  - state S_IDLE; O_grant=0, O_fdma_wareq=0, O_fdma_waddr=0, O_fdma_wsize=0, O_ch_wbusy=0, O_len_err=0.
  - Round-robin pointer = N_CH-1, so client 0 wins first.
  - A reset mid-burst abandons the burst; the master must be reset alongside.
- S_IDLE:
  - If any I_ch_wareq is set, select the first requester searching from pointer+1 modulo N_CH.
  - Registered on that edge: O_grant, O_fdma_waddr, O_fdma_wsize (latched from the selected client), O_fdma_wareq=1, beat counter=0. Go to S_REQ.
  - Latency: request visible at cycle t gives master wareq at t+1.
- S_REQ:
  - O_ch_wbusy[g]=1 for the granted client only, so it drops its request; other clients see 0.
  - Latched addr/size stay stable even after the client drops its request.
  - On I_fdma_wbusy=1: O_fdma_wareq<=0, go to S_BUSY.
- S_BUSY:
  - O_ch_wbusy[g]=1.
  - On I_fdma_wbusy=0: compare beat counter with latched wsize and set O_len_err on mismatch; pointer<=g; go to S_GAP.
- S_GAP:
  - One cycle, all O_ch_wbusy=0, O_grant=0.
  - Lets the finished client observe wbusy low before it re-requests; return to S_IDLE.
- Data path (combinational):
  - O_fdma_wdata = I_ch_wdata slice of the granted client (zero when no grant).
  - O_ch_wvalid[g] = I_fdma_wvalid & O_grant[g].
  - wvalid outside S_REQ/S_BUSY is not forwarded; it sets O_len_err.
- Beat counter: 16 bits, increments on each forwarded wvalid, saturates at 0xFFFF.
- Requests that rise during S_REQ/S_BUSY/S_GAP wait; clients hold their request, no drops.
- Simultaneous requests resolve round-robin from the last owner.
- Throughput limit: the same client can win again only after S_GAP, and only if no other client requests.
- Minimum turnaround between bursts: 2 idle cycles (S_GAP, then S_IDLE).
- Widths: all slices are fixed-offset; there is no arithmetic beyond the pointer modulo and the beat counter.

Optional Feature:
- Macro FDMA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins, pointer ignored. Used when one input must never stall, e.g. the full-screen channel.
- Undefined: round-robin as above.
- All other timing is identical in both modes.

Test Plan:
- Single client 2 requests, waddr=0x1000, wsize=240; master busy for 245 cycles with 240 wvalid beats:
  - O_grant=0b0100 one cycle after request; master waddr=0x1000, wsize=240.
  - O_ch_wvalid[2] pulses 240 times; O_len_err=0.
- Clients 0..3 request simultaneously and continuously: grants appear in order 0,1,2,3,0; each pair of grants separated by the 2 idle cycles. With FDMA_ARB_FIXED_PRIO_EN, client 0 is granted every time.
- Client 1 drops its request one cycle after its wbusy rises while its waddr input changes to 0xDEAD: O_fdma_waddr stays at the latched value through S_BUSY.
- Granted burst with wsize=16 but only 15 wvalid beats before busy falls: O_len_err=1 and stays set until reset.
- I_ui_rst pulsed for 1 cycle while in S_BUSY with client 3 granted: all outputs zero immediately (asynchronously); next request from client 0 is granted normally.
- Wvalid injected while idle: no O_ch_wvalid pulse; O_len_err=1.
